jt51_dac_ser: RTL and testbench

//  Serial DAC transmitter: the outbound end of the sound path, paired with the YM3012-type floating-point DAC.

---
 rtl/jt51_dac_ser.sv | 195 +++++++++++++++++++
 tb/tb_jt51_dac_ser.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_dac_ser.sv
// Serial DAC transmitter for a YM3012-type floating-point DAC.
// Takes signed 16-bit L/R sample pairs, re-encodes each one as a 10-bit
// offset-binary mantissa plus a 3-bit exponent, and shifts both words out
// LSB-first on a single line with SH1/SH2 sample-hold strobes.
module jt51_dac_ser #(
    parameter int SLOT_DIV = 1              // cen pulses per serial bit slot (1..16)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        so,
    output logic        sh1,
    output logic        sh2,
    output logic        frame_sync
);

    localparam logic [3:0] DIV_LAST  = 4'(SLOT_DIV - 1);
    localparam logic [4:0] SLOT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    // Floating-point encode: pick the smallest exponent whose 10-bit window
    // still holds the sign, then flip the mantissa MSB for offset binary.
    // Discarded LSBs are simply dropped, which truncates toward -inf.
    function automatic logic [12:0] encode(input logic signed [15:0] x);
        logic [9:0] m;
        logic [2:0] e;
        if (x[15] != x[14]) begin
            e = 3'd7; m = x[15:6];
        end else if (x[14] != x[13]) begin
            e = 3'd6; m = x[14:5];
        end else if (x[13] != x[12]) begin
            e = 3'd5; m = x[13:4];
        end else if (x[12] != x[11]) begin
            e = 3'd4; m = x[12:3];
        end else if (x[11] != x[10]) begin
            e = 3'd3; m = x[11:2];
        end else if (x[10] != x[9]) begin
            e = 3'd2; m = x[10:1];
        end else begin
            e = 3'd1; m = x[9:0];
        end
        return {e, ~m[9], m[8:0]};
    endfunction

    // Serial bit for a slot: three leading zeros, then the 13-bit word
    // {exponent, tx mantissa} LSB first.
    function automatic logic slot_so(input logic [4:0]  slot,
                                     input logic [12:0] wl,
                                     input logic [12:0] wr);
        logic [3:0]  k;
        logic [3:0]  idx;
        logic [12:0] w;
        k   = slot[3:0];
        idx = k - 4'd3;
        w   = slot[4] ? wr : wl;
        if (k < 4'd3) begin
            return 1'b0;
        end
        return w[idx];
    endfunction

    state_t      state_q, state_d;
    logic        hold_full_q, hold_full_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic [12:0] word_l_q, word_l_d;
    logic [12:0] word_r_q, word_r_d;
    logic [4:0]  slot_q, slot_d;
    logic [3:0]  div_q, div_d;
    logic        so_q, so_d;
    logic        sh1_q, sh1_d;
    logic        sh2_q, sh2_d;
    logic        fs_q, fs_d;
    logic        capture;
    logic        new_slot;

    assign in_ready   = ~hold_full_q;
    assign so         = so_q;
    assign sh1        = sh1_q;
    assign sh2        = sh2_q;
    assign frame_sync = fs_q;

    // Next-state: capture into holding, slot timing, frame-boundary reload
    // and the registered serial outputs for the slot that is starting.
    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        word_l_d    = word_l_q;
        word_r_d    = word_r_q;
        slot_d      = slot_q;
        div_d       = div_q;
        so_d        = so_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        fs_d        = fs_q;
        new_slot    = 1'b0;
        capture     = cen & in_valid & ~hold_full_q;

        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    word_l_d    = encode(hold_l_q);
                    word_r_d    = encode(hold_r_q);
                    hold_full_d = 1'b0;
                    slot_d      = 5'd0;
                    div_d       = 4'd0;
                    new_slot    = 1'b1;
                    state_d     = ST_RUN;
                end
                ST_RUN: begin
                    if (div_q == DIV_LAST) begin
                        div_d    = 4'd0;
                        slot_d   = slot_q + 5'd1;
                        new_slot = 1'b1;
                        // Frame boundary: take a waiting pair, else re-send the old one.
                        if (slot_q == SLOT_LAST && hold_full_q) begin
                            word_l_d    = encode(hold_l_q);
                            word_r_d    = encode(hold_r_q);
                            hold_full_d = 1'b0;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A capture only happens while holding is empty, so it never
            // collides with the boundary reload above.
            if (capture) begin
                hold_l_d    = in_left;
                hold_r_d    = in_right;
                hold_full_d = 1'b1;
            end
        end

        if (new_slot) begin
            so_d  = slot_so(slot_d, word_l_d, word_r_d);
            sh1_d = (slot_d >= 5'd3) && (slot_d <= 5'd15);
            sh2_d = (slot_d >= 5'd19);
            fs_d  = (slot_d == 5'd0);
        end
    end

    // Control state and serial outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            slot_q      <= 5'd0;
            div_q       <= 4'd0;
            so_q        <= 1'b0;
            sh1_q       <= 1'b0;
            sh2_q       <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            slot_q      <= slot_d;
            div_q       <= div_d;
            so_q        <= so_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            fs_q        <= fs_d;
        end
    end

    // Sample data paths; their contents only matter once the matching
    // control flag says they are valid, so they carry no reset.
    always_ff @(posedge clk) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
        word_l_q <= word_l_d;
        word_r_q <= word_r_d;
    end

endmodule

// File: tb/tb_jt51_dac_ser.sv
// Bench for jt51_dac_ser: two instances (SLOT_DIV=1 and SLOT_DIV=4) share
// one random stimulus stream; a reference model predicts the outputs after
// every cen edge into per-instance queues, and a monitor compares them.
module tb_jt51_dac_ser;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_valid;
    logic        rdy_o [2];
    logic        so_o  [2];
    logic        sh1_o [2];
    logic        sh2_o [2];
    logic        fs_o  [2];

    int total;
    int bad;

    jt51_dac_ser #(.SLOT_DIV(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(rdy_o[0]), .so(so_o[0]), .sh1(sh1_o[0]), .sh2(sh2_o[0]),
        .frame_sync(fs_o[0])
    );

    jt51_dac_ser #(.SLOT_DIV(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
        .in_ready(rdy_o[1]), .so(so_o[1]), .sh1(sh1_o[1]), .sh2(sh2_o[1]),
        .frame_sync(fs_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state per instance: 0 idle, 1 load, 2 running.
    int          st   [2];
    int          hf   [2];
    int          pos  [2];
    logic [15:0] hl   [2];
    logic [15:0] hr   [2];
    logic [15:0] cl   [2];
    logic [15:0] cr   [2];
    logic [4:0]  q0 [$];
    logic [4:0]  q1 [$];

    // Smallest exponent whose range [-512, 512) * 2^(e-1) contains x;
    // mantissa is the floor division, offset by 512.
    function automatic void enc(input logic [15:0] x, output int tx, output int e);
        int v;
        v = int'($signed(x));
        e = 7;
        for (int k = 7; k >= 1; k--) begin
            if (v >= -(512 << (k - 1)) && v < (512 << (k - 1))) e = k;
        end
        tx = (v >>> (e - 1)) + 512;
    endfunction

    // {so, sh1, sh2, frame_sync} for a slot number within a frame.
    function automatic logic [3:0] slot_out(input int slot, input logic [15:0] l,
                                            input logic [15:0] r);
        int k, tx, e, b;
        k = slot % 16;
        enc((slot < 16) ? l : r, tx, e);
        if (k < 3)       b = 0;
        else if (k < 13) b = (tx >> (k - 3)) & 1;
        else             b = (e >> (k - 13)) & 1;
        return {b[0], (slot >= 3 && slot <= 15), (slot >= 19), (slot == 0)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; hf[i] = 0; pos[i] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_step(input int i);
        int         d;
        bit         cap;
        logic [3:0] o;
        d   = (i == 0) ? 1 : 4;
        cap = in_valid && (hf[i] == 0);
        case (st[i])
            0: if (cap) st[i] = 1;
            1: begin
                cl[i] = hl[i]; cr[i] = hr[i]; hf[i] = 0; pos[i] = 0; st[i] = 2;
            end
            default: begin
                pos[i]++;
                if (pos[i] == 32 * d) begin
                    pos[i] = 0;
                    if (hf[i] != 0) begin
                        cl[i] = hl[i]; cr[i] = hr[i]; hf[i] = 0;
                    end
                end
            end
        endcase
        if (cap) begin
            hl[i] = in_left; hr[i] = in_right; hf[i] = 1;
        end
        o = (st[i] == 2) ? slot_out(pos[i] / d, cl[i], cr[i]) : 4'b0000;
        if (i == 0) q0.push_back({hf[i] == 0, o});
        else        q1.push_back({hf[i] == 0, o});
    endfunction

    // Model: advances on every enabled clock edge outside reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n && cen) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Monitor: compares each predicted output tuple just after the edge.
    initial begin
        logic [4:0] want;
        logic [4:0] got;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                while ((i == 0 ? q0.size() : q1.size()) > 0) begin
                    want = (i == 0) ? q0.pop_front() : q1.pop_front();
                    got  = {rdy_o[i], so_o[i], sh1_o[i], sh2_o[i], fs_o[i]};
                    total++;
                    if (got !== want) begin
                        bad++;
                        $display("FAIL outputs inst%0d t=%0t {rdy,so,sh1,sh2,fs} got=%b want=%b",
                                 i, $time, got, want);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({rdy_o[i], so_o[i], sh1_o[i], sh2_o[i], fs_o[i]} !== 5'b10000) begin
                bad++;
                $display("FAIL %s inst%0d got=%b want=10000", tag, i,
                         {rdy_o[i], so_o[i], sh1_o[i], sh2_o[i], fs_o[i]});
            end
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_pair(input logic [15:0] l, input logic [15:0] r, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cen = 1'b1; in_valid = 1'b1; in_left = l; in_right = r;
        end
    endtask

    task automatic run_idle(input int cycles, input bit rand_cen);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cen      = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = 1'b0;
            in_left  = 16'($urandom);
            in_right = 16'($urandom);
        end
    endtask

    task automatic run_random(input int cycles);
        logic [15:0] specials [6];
        specials = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFC00, 16'h0100, 16'hFFFF};
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cen      = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 5) == 0);
            in_left  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
            in_right = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        cen      = 1'b0;
        in_valid = 1'b0;
        in_left  = 16'h0000;
        in_right = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset_initial");
        rst_n = 1'b1;

        run_idle(40, 1'b1);
        run_pair(16'h0000, 16'h7FFF, 300);
        run_pair(16'h7FFF, 16'h8000, 300);
        run_pair(16'hFC00, 16'h0100, 300);
        run_pair(16'h0100, 16'hFC00, 300);
        run_pair(16'h8000, 16'hFFFF, 300);
        run_idle(450, 1'b0);

        run_random(2500);
        pulse_reset("reset_midframe");
        run_idle(20, 1'b1);
        run_random(2500);
        pulse_reset("reset_final");

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
